// File: rtl/vx_wnd_spill_fill_unit.sv
// Register-window spill/fill engine: moves one O-register window of a warp between
// the vector register file and that warp's spill stack in memory, one word at a time.
module vx_wnd_spill_fill_unit #(
  parameter int          N          = 8,
  parameter int          W          = 2,
  parameter int          O          = 20,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] SPILL_BASE = 32'h1000_0000
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_spill,
  input  logic [W-1:0] req_warp_id,
  input  logic [N-W-1:0] req_base,
  output logic         rf_rd_en,
  output logic [N-1:0] rf_rd_addr,
  input  logic [31:0]  rf_rd_data,
  output logic         rf_wr_en,
  output logic [N-1:0] rf_wr_addr,
  output logic [31:0]  rf_wr_data,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [31:0]  mem_req_addr,
  output logic [31:0]  mem_req_data,
  input  logic         mem_rsp_valid,
  input  logic [31:0]  mem_rsp_data,
  output logic         done_valid,
  output logic [W-1:0] done_warp_id,
  output logic         done_err
);

  localparam int          NW           = 1 << W;
  localparam int          OW           = N - W;
  localparam int          IW           = $clog2(O);
  localparam logic [31:0] WIN_BYTES    = 32'(4 * O);
  localparam logic [31:0] REGION_BYTES = 32'(4 * O * DEPTH);

  typedef enum logic [2:0] {
    IDLE, SP_RD, SP_LAT, SP_WR, FL_REQ, FL_WAIT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   warp_q;
  logic [OW-1:0]  base_q;
  logic [IW-1:0]  idx_q;
  logic [31:0]    data_q;
  logic           err_q;
  logic [31:0]    sp_q [NW];

  function automatic logic [31:0] region_base(input logic [W-1:0] w);
    return SPILL_BASE + REGION_BYTES * 32'(w);
  endfunction

  logic [31:0] sp_req, base_req, sp_cur, word_addr;
  logic        req_err, last_word;
  logic [N-1:0] reg_addr;

  assign sp_req    = sp_q[req_warp_id];
  assign base_req  = region_base(req_warp_id);
  // A full stack refuses a spill, an empty one refuses a fill.
  assign req_err   = req_spill ? (sp_req == base_req + REGION_BYTES) : (sp_req == base_req);
  assign last_word = (idx_q == IW'(O - 1));
  assign sp_cur    = sp_q[warp_q];
  assign word_addr = sp_cur + (32'(idx_q) << 2);
  assign reg_addr  = {warp_q, base_q + OW'(idx_q)};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output and next-state signal gets a default first, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rf_rd_en      = 1'b0;
    rf_rd_addr    = '0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = '0;
    rf_wr_data    = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    done_valid    = 1'b0;
    done_warp_id  = '0;
    done_err      = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)        state_d = DONE;
          else if (req_spill) state_d = SP_RD;
          else                state_d = FL_REQ;
        end
      end
      SP_RD: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = reg_addr;
        state_d    = SP_LAT;
      end
      SP_LAT: state_d = SP_WR;
      SP_WR: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = word_addr;
        mem_req_data  = data_q;
        if (mem_req_ready) state_d = last_word ? DONE : SP_RD;
      end
      FL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = word_addr;
        if (mem_req_ready) state_d = FL_WAIT;
      end
      FL_WAIT: begin
        if (mem_rsp_valid) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = reg_addr;
          rf_wr_data = mem_rsp_data;
          state_d    = last_word ? DONE : FL_REQ;
        end
      end
      DONE: begin
        done_valid   = 1'b1;
        done_warp_id = warp_q;
        done_err     = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the stack pointers are a small flop array, not a RAM, so they do take a reset value.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      warp_q <= '0;
      base_q <= '0;
      idx_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NW; i++) sp_q[i] <= region_base(W'(i));
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            warp_q <= req_warp_id;
            base_q <= req_base;
            idx_q  <= '0;
            err_q  <= req_err;
            // A fill pops first so the reads target the most recently pushed window.
            if (!req_err && !req_spill) sp_q[req_warp_id] <= sp_req - WIN_BYTES;
          end
        end
        SP_LAT: data_q <= rf_rd_data;
        SP_WR: begin
          if (mem_req_ready) begin
            if (last_word) sp_q[warp_q] <= sp_cur + WIN_BYTES;
            else           idx_q <= idx_q + IW'(1);
          end
        end
        FL_WAIT: begin
          if (mem_rsp_valid && !last_word) idx_q <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_wnd_spill_fill_unit.sv
// Directed bench for the spill/fill engine with simple register-file and memory
// responders; expected addresses and data are written out from the block's defaults.
module tb_vx_wnd_spill_fill_unit;

  logic        clk = 1'b0;
  logic        nRST;
  logic        req_valid, req_ready, req_spill;
  logic [1:0]  req_warp_id;
  logic [5:0]  req_base;
  logic        rf_rd_en, rf_wr_en;
  logic [7:0]  rf_rd_addr, rf_wr_addr;
  logic [31:0] rf_rd_data, rf_wr_data;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        done_valid, done_err;
  logic [1:0]  done_warp_id;

  vx_wnd_spill_fill_unit dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_spill(req_spill),
    .req_warp_id(req_warp_id), .req_base(req_base),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .done_valid(done_valid), .done_warp_id(done_warp_id), .done_err(done_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf_model [256];
  logic [31:0] mem_model [logic [31:0]];
  logic [7:0]  rd_addr_q[$], wr_addr_q[$];
  logic [31:0] wr_data_q[$], mwr_addr_q[$], mwr_data_q[$], mrd_addr_q[$];

  int          cycle, max_stall, rsp_min, rsp_max, stall_rem, rsp_due;
  logic [31:0] rsp_pend, rd_pend_data, held_data;
  logic [33:0] held_ctl;
  bit          rd_pend, held_v;
  int          done_cnt, done_cycle;
  logic        done_err_s;
  logic [1:0]  done_warp_s;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'hBAD0_0000;
  endfunction

  task automatic clear_logs();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    mwr_addr_q.delete(); mwr_data_q.delete(); mrd_addr_q.delete();
    done_cnt = 0; done_cycle = -1;
  endtask

  task automatic reset_env();
    stall_rem = -1; rsp_due = -1; rd_pend = 0; held_v = 0;
  endtask

  // Drives responder inputs just after the rising edge.
  task automatic drive_env();
    rf_rd_data = rd_pend ? rd_pend_data : $urandom();
    rd_pend = 0;
    if (rsp_due == cycle) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = rsp_pend; rsp_due = -1;
    end else begin
      mem_rsp_valid = 1'b0; mem_rsp_data = $urandom();
    end
    if (mem_req_valid) begin
      if (stall_rem < 0) stall_rem = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      mem_req_ready = (stall_rem == 0);
      if (stall_rem > 0) stall_rem--;
    end else begin
      mem_req_ready = (max_stall > 0) ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  endtask

  // Observes the DUT on the falling edge, then advances one cycle.
  task automatic tick();
    @(negedge clk);
    if (held_v) begin
      check("mem_hold_ctl", {mem_req_valid, mem_req_rw, mem_req_addr}, held_ctl);
      check("mem_hold_data", mem_req_data, held_data);
      held_v = 0;
    end
    if (rf_rd_en) begin
      rd_addr_q.push_back(rf_rd_addr);
      rd_pend = 1; rd_pend_data = rf_model[rf_rd_addr];
    end
    if (rf_wr_en) begin
      rf_model[rf_wr_addr] = rf_wr_data;
      wr_addr_q.push_back(rf_wr_addr); wr_data_q.push_back(rf_wr_data);
    end
    if (mem_req_valid) begin
      if (mem_req_ready) begin
        stall_rem = -1;
        if (mem_req_rw) begin
          mem_model[mem_req_addr] = mem_req_data;
          mwr_addr_q.push_back(mem_req_addr); mwr_data_q.push_back(mem_req_data);
        end else begin
          mrd_addr_q.push_back(mem_req_addr);
          rsp_pend = mem_rd(mem_req_addr);
          rsp_due  = cycle + int'($urandom_range(rsp_max, rsp_min));
        end
      end else begin
        held_v = 1; held_ctl = {1'b1, mem_req_rw, mem_req_addr}; held_data = mem_req_data;
      end
    end
    if (done_valid) begin
      done_cnt++; done_cycle = cycle; done_err_s = done_err; done_warp_s = done_warp_id;
    end
    @(posedge clk); #1;
    cycle++;
    drive_env();
  endtask

  task automatic start_req(input bit spill, input logic [1:0] warp, input logic [5:0] base);
    clear_logs();
    req_valid = 1'b1; req_spill = spill; req_warp_id = warp; req_base = base;
    cycle = 0;
    check("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_xfer(input bit spill, input logic [1:0] warp, input logic [5:0] base);
    start_req(spill, warp, base);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    check("xfer_done_seen", done_cnt, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {req_ready, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
                mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
                done_valid, done_warp_id, done_err}, 128'(1) << 120);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rf_model[i] = 32'hC0DE_0000 + 32'(i);
    nRST = 1'b0; req_valid = 1'b0; req_spill = 1'b0; req_warp_id = '0; req_base = '0;
    rf_rd_data = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    max_stall = 0; rsp_min = 1; rsp_max = 1; cycle = 0;
    reset_env(); clear_logs();
    #2 check_reset_outputs("reset_outputs");
    repeat (3) @(posedge clk);
    @(negedge clk) nRST = 1'b1;
    @(posedge clk); #1;
    drive_env();

    // Spill warp 1, base 0x14.
    run_xfer(1'b1, 2'd1, 6'h14);
    check("spill_done_cycle", done_cycle, 61);
    check("spill_done_err", done_err_s, 1'b0);
    check("spill_done_warp", done_warp_s, 2'd1);
    check("spill_rd_count", rd_addr_q.size(), 20);
    check("spill_wr_count", mwr_addr_q.size(), 20);
    for (int i = 0; i < 20 && i < rd_addr_q.size() && i < mwr_addr_q.size(); i++) begin
      check("spill_rf_addr", rd_addr_q[i], 8'h54 + 8'(i));
      check("spill_mem_addr", mwr_addr_q[i], 32'h1000_0280 + 32'(4 * i));
      check("spill_mem_data", mwr_data_q[i], 32'hC0DE_0054 + 32'(i));
    end
    check("spill_sp1", dut.sp_q[1], 32'h1000_02D0);

    // Fill warp 1 into base 0x28, zero-wait memory.
    run_xfer(1'b0, 2'd1, 6'h28);
    check("fill_done_cycle", done_cycle, 41);
    check("fill_done_err", done_err_s, 1'b0);
    check("fill_rd_count", mrd_addr_q.size(), 20);
    check("fill_wr_count", wr_addr_q.size(), 20);
    for (int i = 0; i < 20 && i < mrd_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check("fill_mem_addr", mrd_addr_q[i], 32'h1000_0280 + 32'(4 * i));
      check("fill_rf_addr", wr_addr_q[i], 8'h68 + 8'(i));
      check("fill_rf_data", wr_data_q[i], 32'hC0DE_0054 + 32'(i));
    end
    check("fill_sp1", dut.sp_q[1], 32'h1000_0280);

    // Offset wrap inside warp 0's bank.
    run_xfer(1'b1, 2'd0, 6'h3C);
    check("wrap_done_err", done_err_s, 1'b0);
    check("wrap_rd_count", rd_addr_q.size(), 20);
    for (int i = 0; i < 20 && i < rd_addr_q.size(); i++)
      check("wrap_rf_addr", rd_addr_q[i], (i < 4) ? 8'h3C + 8'(i) : 8'(i - 4));

    // Fill of an empty stack.
    run_xfer(1'b0, 2'd3, 6'h00);
    check("uflow_done_cycle", done_cycle, 1);
    check("uflow_done_err", done_err_s, 1'b1);
    check("uflow_done_warp", done_warp_s, 2'd3);
    check("uflow_traffic", rd_addr_q.size() + wr_addr_q.size() + mwr_addr_q.size() + mrd_addr_q.size(), 0);
    check("uflow_sp3", dut.sp_q[3], 32'h1000_0780);

    // Fill warp 2's stack, then overflow it.
    for (int k = 0; k < 8; k++) begin
      run_xfer(1'b1, 2'd2, 6'h00);
      check("push_done_err", done_err_s, 1'b0);
      check("push_first_addr", (mwr_addr_q.size() > 0) ? mwr_addr_q[0] : 32'hFFFF_FFFF,
            32'h1000_0500 + 32'(k * 32'h50));
    end
    check("push_last_addr", (mwr_addr_q.size() == 20) ? mwr_addr_q[19] : 32'hFFFF_FFFF, 32'h1000_077C);
    run_xfer(1'b1, 2'd2, 6'h00);
    check("oflow_done_cycle", done_cycle, 1);
    check("oflow_done_err", done_err_s, 1'b1);
    check("oflow_traffic", rd_addr_q.size() + wr_addr_q.size() + mwr_addr_q.size() + mrd_addr_q.size(), 0);
    check("oflow_sp2", dut.sp_q[2], 32'h1000_0780);

    // Stray response while idle must not write the register file.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    check("stray_no_rf_wr", rf_wr_en, 1'b0);
    check("stray_idle", req_ready, 1'b1);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;

    // Backpressure and variable response delay on warp 3.
    max_stall = 5; rsp_min = 1; rsp_max = 7;
    run_xfer(1'b1, 2'd3, 6'h05);
    check("bp_spill_err", done_err_s, 1'b0);
    check("bp_spill_count", mwr_addr_q.size(), 20);
    for (int i = 0; i < 20 && i < mwr_addr_q.size() && i < rd_addr_q.size(); i++) begin
      check("bp_spill_rf_addr", rd_addr_q[i], 8'hC5 + 8'(i));
      check("bp_spill_mem_addr", mwr_addr_q[i], 32'h1000_0780 + 32'(4 * i));
      check("bp_spill_mem_data", mwr_data_q[i], 32'hC0DE_00C5 + 32'(i));
    end
    run_xfer(1'b0, 2'd3, 6'h30);
    check("bp_fill_err", done_err_s, 1'b0);
    check("bp_fill_count", wr_addr_q.size(), 20);
    for (int i = 0; i < 20 && i < wr_addr_q.size() && i < mrd_addr_q.size(); i++) begin
      check("bp_fill_mem_addr", mrd_addr_q[i], 32'h1000_0780 + 32'(4 * i));
      check("bp_fill_rf_addr", wr_addr_q[i], (i < 16) ? 8'hF0 + 8'(i) : 8'hC0 + 8'(i - 16));
      check("bp_fill_rf_data", wr_data_q[i], 32'hC0DE_00C5 + 32'(i));
    end
    check("bp_sp3", dut.sp_q[3], 32'h1000_0780);

    // Reset in the middle of word 7 of a warp 0 spill.
    max_stall = 0; rsp_min = 1; rsp_max = 1;
    start_req(1'b1, 2'd0, 6'h00);
    for (int i = 0; i < 200 && rd_addr_q.size() < 8; i++) tick();
    check("mid_reached_word7", rd_addr_q.size(), 8);
    #2 nRST = 1'b0;
    #1 check_reset_outputs("mid_reset_outputs");
    check("mid_reset_sp0", dut.sp_q[0], 32'h1000_0000);
    check("mid_reset_sp2", dut.sp_q[2], 32'h1000_0500);
    reset_env();
    repeat (2) @(posedge clk);
    @(negedge clk) nRST = 1'b1;
    @(posedge clk); #1;
    drive_env();
    tick(); tick();
    check("mid_no_done", done_cnt, 0);
    run_xfer(1'b1, 2'd0, 6'h3C);
    check("post_rst_done_cycle", done_cycle, 61);
    check("post_rst_done_err", done_err_s, 1'b0);
    check("post_rst_first_addr", (mwr_addr_q.size() > 0) ? mwr_addr_q[0] : 32'hFFFF_FFFF, 32'h1000_0000);
    check("post_rst_first_data", (mwr_data_q.size() > 0) ? mwr_data_q[0] : 32'hFFFF_FFFF, 32'hC0DE_003C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_wnd_spill_fill_unit.md
# VX_wnd_spill_fill_unit

Per-core register-window spill/fill engine. It is the responder to the window decode unit's `deschedule` request. On window overflow it copies one O-register window of a warp from the vector register file to a per-warp spill stack in memory. On underflow it copies the most recently spilled window back. When the transfer is done it signals the warp scheduler to reschedule that warp. Only one transfer is in flight at a time.

## Interface
- `N`, 8, log2 of vector registers (all warps)
- `W`, 2, log2 of warp count
- `O`, 20, registers per window ("in" + "local")
- `DEPTH`, 8, windows per warp spill stack
- `SPILL_BASE`, 32'h1000_0000, byte address of warp 0 spill region; warp w region base = SPILL_BASE + w*4*O*DEPTH
- `clk` in 1 clock
- `nRST` in 1 reset; asynchronous, active-low
- `req_valid` in 1 transfer request, from the window decode unit's deschedule path
- `req_ready` out 1 engine idle, request accepted on `req_valid && req_ready`
- `req_spill` in 1 1 = spill (overflow), 0 = fill (underflow)
- `req_warp_id` in W warp to service
- `req_base` in N-W physical offset of the window within the warp's register bank
- `rf_rd_en` out 1 register file read strobe; data returns the next cycle
- `rf_rd_addr` out N {warp_id, offset}
- `rf_rd_data` in 32 read data, valid the cycle after `rf_rd_en`
- `rf_wr_en` out 1 register file write strobe
- `rf_wr_addr` out N {warp_id, offset}
- `rf_wr_data` out 32 write data
- `mem_req_valid` out 1 memory request
- `mem_req_ready` in 1 memory accepts request
- `mem_req_rw` out 1 1 = write, 0 = read
- `mem_req_addr` out 32 word-aligned byte address
- `mem_req_data` out 32 write data
- `mem_rsp_valid` in 1 read response
- `mem_rsp_data` in 32 read data
- `done_valid` out 1 one-cycle pulse: transfer finished, reschedule warp
- `done_warp_id` out W warp that finished
- `done_err` out 1 qualifies `done_valid`: spill-stack overflow or underflow

## Operation
- **Per-warp state:** stack pointer `sp[w]`, 32 bits. Reset value is the region base of warp w. Word counter `idx` counts 0..O-1 and is $clog2(O) bits wide.
- **Register address:** {warp_id, (req_base + idx) mod 2^(N-W)}. The offset wraps inside the warp's bank.
- **States:** IDLE, SP_RD, SP_LAT, SP_WR, FL_REQ, FL_WAIT, DONE.
- **IDLE:** `req_ready`=1. On accept, latch the warp, base and direction, and clear `idx`.
  - Spill when `sp` = region base + 4*O*DEPTH: go to DONE with err.
  - Fill when `sp` = region base: go to DONE with err.
  - Otherwise a spill goes to SP_RD. A fill sets `sp` -= 4*O and goes to FL_REQ.
- **SP_RD:** assert `rf_rd_en` for one cycle, then go to SP_LAT.
- **SP_LAT:** latch `rf_rd_data` into the data register, then go to SP_WR.
- **SP_WR:** drive `mem_req_valid`=1, rw=1, addr = `sp` + 4*idx, data = latched register. Hold all of these until `mem_req_ready`. Then:
  - if idx = O-1: `sp` += 4*O and go to DONE;
  - otherwise idx++ and go to SP_RD.
- **FL_REQ:** drive `mem_req_valid`=1, rw=0, addr = `sp` + 4*idx. Hold until `mem_req_ready`, then go to FL_WAIT.
- **FL_WAIT:** on `mem_rsp_valid`, drive `rf_wr_en`=1 in the same cycle with `rf_wr_data` = `mem_rsp_data`. Then:
  - if idx = O-1: go to DONE;
  - otherwise idx++ and go to FL_REQ.
- **DONE:** `done_valid`=1 for exactly one cycle, with `done_warp_id` and `done_err`. Then go to IDLE.
- **Error path:** `sp`, the register file and memory are all untouched.
- **Stray responses:** `mem_rsp_valid` outside FL_WAIT is ignored. At most one memory read is outstanding.
- **Back-to-back requests:** a request for the same warp is legal once the engine returns to IDLE. `sp` reflects the prior transfer.

## Timing
- **Reset:** asserting `nRST` asynchronously forces IDLE, all `sp` to their region bases, `idx`=0, and the data register to 0.
  - All outputs are 0 during reset, except `req_ready`=1.
  - Reset mid-transfer abandons the transfer. No `done_valid` is issued. Any outstanding memory response after reset is ignored.
- **Strobes:** `rf_rd_en`, `rf_wr_en` and `done_valid` are single-cycle. `mem_req_*` is stable while valid and not yet ready.
- **Start:** the first `rf_rd_en` or `mem_req_valid` is in the cycle after accept.
- **Spill latency** with `mem_req_ready` always 1: 3 cycles per word. O=20 gives 60 cycles; `done_valid` is in cycle 61 after accept.
- **Fill latency** with zero-wait ready and the response one cycle after accept: 2 cycles per word, 40 cycles, then `done_valid`.
- **Error latency:** accept, then `done_valid` the next cycle.

## Test plan
- **Spill:** spill warp 1, base 0x14, ready always 1.
  - Reads rf 0x54..0x67.
  - Writes mem 0x1000_0280..0x1000_02CC, with data matching the rf.
  - `sp[1]` = 0x1000_02D0; `done_valid` at cycle 61 with err=0.
- **Fill after spill:** fill warp 1, base 0x28.
  - Reads mem 0x1000_0280..0x1000_02CC.
  - Writes rf 0x68..0x7B with the spilled data.
  - `sp[1]` back to 0x1000_0280.
- **Wrap:** spill warp 0, base 0x3C. rf read addresses are 0x3C..0x3F, then 0x00..0x0F.
- **Errors:**
  - Fill warp 3 after reset gives `done_err`=1 the cycle after accept, with no mem or rf traffic.
  - Eight spills of warp 2 succeed; the ninth errors and `sp[2]` stays at 0x1000_0780.
- **Backpressure and stray response:** random `mem_req_ready` stalls of 0-5 cycles and response delays of 1-7 cycles. Addresses and data must stay stable and correct. A `mem_rsp_valid` pulse injected in IDLE causes no rf write.
- **Mid-transfer reset:** assert `nRST` during the spill of word 7.
  - Outputs go to their reset values immediately; `sp` returns to its base; no `done_valid`.
  - A new request after release completes normally.
